// File: rtl/urv_writeback_pkg.sv
// rtl/urv_writeback_pkg.sv - shared encodings for the uRV writeback stage
package urv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
   localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
   localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;

   typedef enum logic [1:0] {
      WB_IDLE       = 2'b00,
      WB_LOAD_WAIT  = 2'b01,
      WB_STORE_WAIT = 2'b10
   } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// rtl/urv_load_align.sv - extracts and extends a byte/half/word from a load data word
module urv_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  fun_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_i)
         2'd0:    byte_sel = data_i[7:0];
         2'd1:    byte_sel = data_i[15:8];
         2'd2:    byte_sel = data_i[23:16];
         default: byte_sel = data_i[31:24];
      endcase
      half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
   end

   always_comb begin
      data_o = data_i;
      case (fun_i)
         LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data_o = {24'h000000, byte_sel};
         LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data_o = {16'h0000, half_sel};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// rtl/urv_writeback.sv - uRV writeback: rd select, memory completion tracking, bypass hold
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int g_mem_timeout = 16,
   parameter int g_with_bypass = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        w_stall_i,
   output logic        w_stall_req_o,
   input  logic        x_valid_i,
   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [4:0]  x_rd_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_rd_value_i,
   input  logic [1:0]  x_rd_source_i,
   input  logic [31:0] x_rd_shifter_i,
   input  logic [31:0] x_rd_multiply_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic        x_ecc_flip_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,
   output logic        rf_ecc_flip_o,
   output logic [4:0]  w_bypass_rd_o,
   output logic [31:0] w_bypass_value_o,
   output logic        w_bypass_write_o,
   output logic        w_bus_err_o
);

   localparam int CW = (g_mem_timeout > 1) ? $clog2(g_mem_timeout) : 1;

   wb_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [4:0]     rd_q, rd_d;
   logic [2:0]     fun_q, fun_d;
   logic [1:0]     addr_q, addr_d;
   logic           ecc_q, ecc_d;
   logic           wr_q, wr_d;

   logic [2:0]     al_fun;
   logic [1:0]     al_addr;
   logic [31:0]    al_data;
   logic [31:0]    exe_value;
   logic           expire;
   logic           wr_en, ecc_en, stall_req, bus_err;
   logic [4:0]     wr_rd;
   logic [31:0]    wr_value;
   logic           unused_addr;

   assign unused_addr = ^x_dm_addr_i[31:2];

   // In the wait states the aligner must use the fields captured at issue time
   assign al_fun  = (state_q == WB_IDLE) ? x_fun_i : fun_q;
   assign al_addr = (state_q == WB_IDLE) ? x_dm_addr_i[1:0] : addr_q;
   assign expire  = (g_mem_timeout != 0) && (cnt_q == CW'(g_mem_timeout - 1));

   urv_load_align u_load_align (
      .fun_i  (al_fun),
      .addr_i (al_addr),
      .data_i (dm_data_l_i),
      .data_o (al_data)
   );

   always_comb begin
      exe_value = x_rd_value_i;
      case (x_rd_source_i)
         RD_SOURCE_SHIFTER:  exe_value = x_rd_shifter_i;
         RD_SOURCE_MULTIPLY: exe_value = x_rd_multiply_i;
         default:            exe_value = x_rd_value_i;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      fun_d     = fun_q;
      addr_d    = addr_q;
      ecc_d     = ecc_q;
      wr_d      = wr_q;
      wr_en     = 1'b0;
      wr_rd     = x_rd_i;
      wr_value  = exe_value;
      ecc_en    = x_ecc_flip_i;
      stall_req = 1'b0;
      bus_err   = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (x_valid_i && !w_stall_i) begin
               if (x_load_i) begin
                  wr_value = al_data;
                  if (dm_load_done_i) begin
                     wr_en = x_rd_write_i;
                  end else begin
                     state_d = WB_LOAD_WAIT;
                     cnt_d   = '0;
                     rd_d    = x_rd_i;
                     fun_d   = x_fun_i;
                     addr_d  = x_dm_addr_i[1:0];
                     ecc_d   = x_ecc_flip_i;
                     wr_d    = x_rd_write_i;
                  end
               end else if (x_store_i) begin
                  if (!dm_store_done_i) begin
                     state_d = WB_STORE_WAIT;
                     cnt_d   = '0;
                  end
               end else begin
                  wr_en = x_rd_write_i;
               end
            end
         end
         WB_LOAD_WAIT: begin
            wr_rd    = rd_q;
            wr_value = al_data;
            ecc_en   = ecc_q;
            if (dm_load_done_i) begin
               wr_en   = wr_q;
               state_d = WB_IDLE;
            end else if (expire) begin
               bus_err = 1'b1;
               state_d = WB_IDLE;
            end else begin
               stall_req = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         WB_STORE_WAIT: begin
            if (dm_store_done_i) begin
               state_d = WB_IDLE;
            end else if (expire) begin
               bus_err = 1'b1;
               state_d = WB_IDLE;
            end else begin
               stall_req = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         default: state_d = WB_IDLE;
      endcase
      if (wr_rd == 5'd0) begin
         wr_en = 1'b0;
      end
      if (rst_i) begin
         state_d   = WB_IDLE;
         cnt_d     = '0;
         wr_en     = 1'b0;
         wr_rd     = 5'd0;
         wr_value  = 32'h0;
         stall_req = 1'b0;
         bus_err   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= WB_IDLE;
         cnt_q   <= '0;
         rd_q    <= 5'd0;
         fun_q   <= 3'd0;
         addr_q  <= 2'd0;
         ecc_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         fun_q   <= fun_d;
         addr_q  <= addr_d;
         ecc_q   <= ecc_d;
         wr_q    <= wr_d;
      end
   end

   assign rf_rd_o       = wr_rd;
   assign rf_rd_value_o = wr_value;
   assign rf_rd_write_o = wr_en;
   assign rf_ecc_flip_o = ecc_en & wr_en;
   assign w_stall_req_o = stall_req;
   assign w_bus_err_o   = bus_err;

   if (g_with_bypass != 0) begin : g_bypass
      logic [4:0]  byp_rd_q;
      logic [31:0] byp_value_q;
      logic        byp_write_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            byp_rd_q    <= 5'd0;
            byp_value_q <= 32'h0;
            byp_write_q <= 1'b0;
         end else begin
            byp_write_q <= wr_en;
            if (wr_en) begin
               byp_rd_q    <= wr_rd;
               byp_value_q <= wr_value;
            end
         end
      end

      assign w_bypass_rd_o    = byp_rd_q;
      assign w_bypass_value_o = byp_value_q;
      assign w_bypass_write_o = byp_write_q & ~rst_i;
   end else begin : g_no_bypass
      assign w_bypass_rd_o    = 5'd0;
      assign w_bypass_value_o = 32'h0;
      assign w_bypass_write_o = 1'b0;
   end

endmodule

// File: tb/tb_urv_writeback.sv
// tb/tb_urv_writeback.sv - directed self-checking bench for urv_writeback
module tb_urv_writeback;
   import urv_writeback_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        w_stall, w_stall_req;
   logic        x_valid, x_load, x_store, x_rd_write, x_ecc;
   logic [2:0]  x_fun;
   logic [4:0]  x_rd;
   logic [31:0] x_value, x_shift, x_mul, x_addr;
   logic [1:0]  x_src;
   logic [31:0] dm_data;
   logic        ld_done, st_done;
   logic [4:0]  rf_rd, byp_rd;
   logic [31:0] rf_value, byp_value;
   logic        rf_write, rf_ecc, byp_write, bus_err;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
   } wr_t;

   wr_t sb[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   urv_writeback #(.g_mem_timeout(16), .g_with_bypass(1)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .w_stall_i       (w_stall),
      .w_stall_req_o   (w_stall_req),
      .x_valid_i       (x_valid),
      .x_fun_i         (x_fun),
      .x_load_i        (x_load),
      .x_store_i       (x_store),
      .x_rd_i          (x_rd),
      .x_rd_write_i    (x_rd_write),
      .x_rd_value_i    (x_value),
      .x_rd_source_i   (x_src),
      .x_rd_shifter_i  (x_shift),
      .x_rd_multiply_i (x_mul),
      .x_dm_addr_i     (x_addr),
      .x_ecc_flip_i    (x_ecc),
      .dm_data_l_i     (dm_data),
      .dm_load_done_i  (ld_done),
      .dm_store_done_i (st_done),
      .rf_rd_o         (rf_rd),
      .rf_rd_value_o   (rf_value),
      .rf_rd_write_o   (rf_write),
      .rf_ecc_flip_o   (rf_ecc),
      .w_bypass_rd_o   (byp_rd),
      .w_bypass_value_o(byp_value),
      .w_bypass_write_o(byp_write),
      .w_bus_err_o     (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      wr_t e;
      if (rf_write === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_write", {31'd0, rf_write}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
            chk("sb_value", rf_value, e.value);
         end
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] value);
      wr_t e;
      e.rd    = rd;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic clr();
      x_valid = 0; x_load = 0; x_store = 0; x_rd_write = 0; x_ecc = 0;
      x_fun = 3'd0; x_rd = 5'd0; x_value = 0; x_shift = 0; x_mul = 0;
      x_addr = 0; x_src = RD_SOURCE_ALU; dm_data = 0; ld_done = 0; st_done = 0;
      w_stall = 0;
   endtask

   task automatic settle();
      #1;
      sb_check();
   endtask

   task automatic next();
      @(negedge clk);
      clr();
   endtask

   task automatic alu(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] v);
      x_valid = 1; x_rd = rd; x_rd_write = 1; x_src = src;
      x_value = 32'h0BAD_0000; x_shift = 32'h0BAD_0001; x_mul = 32'h0BAD_0002;
      case (src)
         RD_SOURCE_SHIFTER:  x_shift = v;
         RD_SOURCE_MULTIPLY: x_mul = v;
         default:            x_value = v;
      endcase
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] fun, input logic [1:0] a);
      x_valid = 1; x_load = 1; x_rd = rd; x_rd_write = 1; x_fun = fun;
      x_addr = {30'h1000_0000, a};
   endtask

   initial begin
      clr();
      rst = 1;
      @(negedge clk);
      alu(5'd4, RD_SOURCE_ALU, 32'hAAAA_5555);
      ld_done = 1;
      settle();
      chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
      chk("rst_stall", {31'd0, w_stall_req}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_byp_write", {31'd0, byp_write}, 32'd0);
      next();
      settle();
      chk("rst_byp_write2", {31'd0, byp_write}, 32'd0);
      rst = 0;
      next();

      // ALU write and one-cycle bypass
      alu(5'd5, RD_SOURCE_ALU, 32'h1234_5678);
      push(5'd5, 32'h1234_5678);
      settle();
      chk("alu_write", {31'd0, rf_write}, 32'd1);
      chk("alu_stall", {31'd0, w_stall_req}, 32'd0);
      next();
      settle();
      chk("byp_valid", {31'd0, byp_write}, 32'd1);
      chk("byp_rd", {27'd0, byp_rd}, 32'd5);
      chk("byp_value", byp_value, 32'h1234_5678);
      next();
      settle();
      chk("byp_clear", {31'd0, byp_write}, 32'd0);

      alu(5'd6, RD_SOURCE_SHIFTER, 32'hF0F0_0F0F);
      push(5'd6, 32'hF0F0_0F0F);
      settle();
      chk("shift_write", {31'd0, rf_write}, 32'd1);
      next();
      alu(5'd7, RD_SOURCE_MULTIPLY, 32'h0000_CAFE);
      x_ecc = 1;
      push(5'd7, 32'h0000_CAFE);
      settle();
      chk("mul_ecc", {31'd0, rf_ecc}, 32'd1);
      next();

      // Stage stall blocks acceptance; stray done pulses are ignored
      alu(5'd14, RD_SOURCE_ALU, 32'h1111_2222);
      w_stall = 1;
      settle();
      chk("wstall_no_write", {31'd0, rf_write}, 32'd0);
      next();
      ld_done = 1; st_done = 1;
      settle();
      chk("stray_done_write", {31'd0, rf_write}, 32'd0);
      next();
      settle();
      chk("stray_done_stall", {31'd0, w_stall_req}, 32'd0);

      // Loads completing in the issue cycle
      load(5'd8, LDST_B, 2'd3);
      dm_data = 32'h80AA_BBCC; ld_done = 1;
      push(5'd8, 32'hFFFF_FF80);
      settle();
      chk("lb_write", {31'd0, rf_write}, 32'd1);
      next();
      settle();
      chk("lb_stall", {31'd0, w_stall_req}, 32'd0);
      load(5'd9, LDST_BU, 2'd3);
      dm_data = 32'h80AA_BBCC; ld_done = 1;
      push(5'd9, 32'h0000_0080);
      settle();
      next();
      load(5'd15, LDST_HU, 2'd0);
      dm_data = 32'h1234_9ABC; ld_done = 1;
      push(5'd15, 32'h0000_9ABC);
      settle();
      next();
      load(5'd16, LDST_L, 2'd0);
      dm_data = 32'hDEAD_BEEF; ld_done = 1;
      push(5'd16, 32'hDEAD_BEEF);
      settle();
      next();

      // LH waiting three cycles, latched rd/fun/addr/ecc
      load(5'd10, LDST_H, 2'd2);
      x_ecc = 1;
      push(5'd10, 32'hFFFF_8001);
      settle();
      chk("lh_issue_nowrite", {31'd0, rf_write}, 32'd0);
      chk("lh_issue_stall", {31'd0, w_stall_req}, 32'd0);
      next();
      for (int i = 0; i < 3; i++) begin
         x_rd = 5'd3; x_fun = LDST_L; x_addr = 32'h0;
         settle();
         chk("lh_wait_stall", {31'd0, w_stall_req}, 32'd1);
         chk("lh_wait_nowrite", {31'd0, rf_write}, 32'd0);
         next();
      end
      ld_done = 1; dm_data = 32'h8001_7FFF; x_rd = 5'd3;
      settle();
      chk("lh_done_write", {31'd0, rf_write}, 32'd1);
      chk("lh_done_stall", {31'd0, w_stall_req}, 32'd0);
      chk("lh_done_ecc", {31'd0, rf_ecc}, 32'd1);
      next();
      settle();
      chk("lh_byp_rd", {27'd0, byp_rd}, 32'd10);
      chk("lh_byp_valid", {31'd0, byp_write}, 32'd1);

      // Store waiting two cycles, then store completing at issue
      x_valid = 1; x_store = 1; x_rd = 5'd2;
      settle();
      next();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("st_wait_stall", {31'd0, w_stall_req}, 32'd1);
         next();
      end
      st_done = 1;
      settle();
      chk("st_done_stall", {31'd0, w_stall_req}, 32'd0);
      chk("st_done_nowrite", {31'd0, rf_write}, 32'd0);
      next();
      x_valid = 1; x_store = 1; st_done = 1;
      settle();
      next();
      settle();
      chk("st_fast_stall", {31'd0, w_stall_req}, 32'd0);

      // Timeout with no completion
      load(5'd11, LDST_L, 2'd0);
      settle();
      next();
      for (int i = 0; i < 15; i++) begin
         settle();
         chk("to_wait_stall", {31'd0, w_stall_req}, 32'd1);
         chk("to_wait_err", {31'd0, bus_err}, 32'd0);
         next();
      end
      settle();
      chk("to_err_pulse", {31'd0, bus_err}, 32'd1);
      chk("to_no_write", {31'd0, rf_write}, 32'd0);
      chk("to_stall_rel", {31'd0, w_stall_req}, 32'd0);
      next();
      settle();
      chk("to_err_clear", {31'd0, bus_err}, 32'd0);
      chk("to_idle_stall", {31'd0, w_stall_req}, 32'd0);

      // Completion on the last allowed cycle wins over timeout
      load(5'd12, LDST_L, 2'd0);
      push(5'd12, 32'hC0DE_F00D);
      settle();
      next();
      for (int i = 0; i < 15; i++) begin
         settle();
         next();
      end
      ld_done = 1; dm_data = 32'hC0DE_F00D;
      settle();
      chk("late_done_err", {31'd0, bus_err}, 32'd0);
      chk("late_done_write", {31'd0, rf_write}, 32'd1);
      next();

      // Load to x0 never writes or updates bypass
      load(5'd0, LDST_L, 2'd0);
      dm_data = 32'h5555_AAAA; ld_done = 1; x_ecc = 1;
      settle();
      chk("x0_nowrite", {31'd0, rf_write}, 32'd0);
      chk("x0_noecc", {31'd0, rf_ecc}, 32'd0);
      next();
      settle();
      chk("x0_byp_invalid", {31'd0, byp_write}, 32'd0);

      // Reset in the middle of a pending load
      load(5'd13, LDST_L, 2'd0);
      settle();
      next();
      settle();
      chk("rstw_stall_before", {31'd0, w_stall_req}, 32'd1);
      rst = 1;
      settle();
      chk("rstw_stall", {31'd0, w_stall_req}, 32'd0);
      chk("rstw_nowrite", {31'd0, rf_write}, 32'd0);
      next();
      rst = 0;
      ld_done = 1; dm_data = 32'h7777_7777;
      settle();
      chk("rstw_done_nowrite", {31'd0, rf_write}, 32'd0);
      chk("rstw_done_err", {31'd0, bus_err}, 32'd0);
      chk("rstw_done_stall", {31'd0, w_stall_req}, 32'd0);
      next();
      alu(5'd17, RD_SOURCE_ALU, 32'h0000_0017);
      push(5'd17, 32'h0000_0017);
      settle();
      chk("rstw_alu_write", {31'd0, rf_write}, 32'd1);
      next();

      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
